// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: multi-cycle shift-left controller wrapped around an
// external combinational ALU. A request (operand, count) is accepted on a
// valid/ready handshake, then the ALU is driven with the shift-left-by-one
// opcode once per clock, its Z output being fed back as the next A operand.
// The final value and a sticky signed-overflow flag are offered on a
// valid/ready output handshake. in_data/out_data are two's-complement values.
module alu_shift_sequencer #(
   parameter int          nIO    = 8,
   parameter int          CNT_W  = 4,
   parameter logic [2:0]  OP_SHL = 3'b100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [nIO-1:0]   in_data,
   input  logic [CNT_W-1:0] in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [nIO-1:0]   out_data,
   output logic             out_ov,
   output logic [nIO-1:0]   alu_a,
   output logic [nIO-1:0]   alu_b,
   output logic [2:0]       alu_op,
   input  logic [nIO-1:0]   alu_z
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [nIO-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ov_q, ov_d;

   // The ALU always performs shift-left-by-one on the accumulator; B is unused by that op.
   always_comb begin
      alu_a  = acc_q;
      alu_b  = '0;
      alu_op = OP_SHL;
   end

   // Handshake and result outputs; both handshakes are masked while reset is asserted.
   always_comb begin
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = (state_q == DONE) && !rst;
      out_data  = acc_q;
      out_ov    = ov_q;
   end

   // Next-state logic: load on accept, one ALU step per RUN cycle, hold in DONE until taken.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ov_d    = ov_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = in_data;
               cnt_d   = in_count;
               ov_d    = 1'b0;
               state_d = (in_count != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            acc_d = alu_z;
            cnt_d = cnt_q - CNT_W'(1);
            // This step moves bit nIO-2 into the sign position; flag a sign change.
            ov_d  = ov_q | (acc_q[nIO-1] ^ acc_q[nIO-2]);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Returning to IDLE here means the earliest new accept is the next cycle.
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
      end
   end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Testbench for alu_shift_sequencer: models the downstream ALU (Z = A << 1),
// pushes the expected result of every accepted request into a scoreboard
// queue, and a monitor process compares each presented result against it.
module tb_alu_shift_sequencer;

   localparam int N = 8;
   localparam int C = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic [C-1:0] in_count;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         out_ov;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [2:0]   alu_op;
   logic [N-1:0] alu_z;

   alu_shift_sequencer #(.nIO(N), .CNT_W(C), .OP_SHL(3'b100)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_count(in_count),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ov(out_ov),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z)
   );

   // Combinational ALU stand-in: shift-left-by-one, zero fill.
   assign alu_z = alu_a << 1;

   typedef struct {
      logic [N-1:0] d;
      logic         ov;
      int           lat;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   cyc;
   int   hs_cyc;
   bit   seen;
   bit   rand_rdy;
   bit   force_rdy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // out_ready is either forced by the stimulus or randomised every cycle.
   always @(posedge clk) begin
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: result is the operand shifted left by count, truncated.
   // Overflow is set iff the bits that pass through the sign position
   // (operand bits N-1 down to N-1-count, zeros below) are not all equal.
   function automatic void model(input logic [N-1:0] d, input int c,
                                 output logic [N-1:0] r, output logic ov);
      logic [2*N-1:0] x;
      int             ones;
      x    = {d, {N{1'b0}}};
      r    = N'((longint'(d) << c) & ((longint'(1) << N) - 1));
      ones = 0;
      for (int k = 0; k <= c; k++) ones += int'(x[2*N-1-k]);
      ov   = (ones != 0) && (ones != c + 1);
   endfunction

   task automatic send(input logic [N-1:0] d, input logic [C-1:0] c, output int acc_cyc);
      bit   ok;
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      in_count = c;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      acc_cyc = cyc;
      if (ok) begin
         model(d, int'(c), e.d, e.ov);
         e.lat = int'(c) + 1;
         e.acc = cyc;
         exp_q.push_back(e);
      end else begin
         chk("accept_timeout", 32'd0, 32'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = N'($urandom);
      in_count = C'($urandom);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_out_valid();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: checks ALU drive every cycle and every presented result against the queue.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         chk("alu_op", 32'(alu_op), 32'h4);
         chk("alu_b", 32'(alu_b), 32'h0);
         if (rst) begin
            seen = 1'b0;
         end else if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q[0];
               if (!seen) begin
                  chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                  seen = 1'b1;
               end
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_ov", 32'(out_ov), 32'(e.ov));
               chk("in_ready_in_done", 32'(in_ready), 32'd0);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  seen   = 1'b0;
                  hs_cyc = cyc;
               end
            end
         end
      end
   endtask

   initial begin
      int a;
      int b;
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      hs_cyc    = 0;
      seen      = 1'b0;
      rand_rdy  = 1'b0;
      force_rdy = 1'b1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_count  = '0;
      out_ready = 1'b0;

      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_out_data", 32'(out_data), 32'd0);
      chk("post_rst_out_ov", 32'(out_ov), 32'd0);

      // Directed cases: basic, sign overflow, zero count, over-shift
      send(8'h03, 4'd3, a); drain();
      send(8'h40, 4'd1, a); drain();
      send(8'hA5, 4'd0, a); drain();
      send(8'h01, 4'd9, a); drain();
      send(8'h81, 4'd15, a); drain();

      // Backpressure: result held 5 cycles while a new request waits
      force_rdy = 1'b0;
      send(8'h03, 4'd2, a);
      wait_out_valid();
      fork
         send(8'h21, 4'd2, b);
         begin
            repeat (5) @(posedge clk);
            force_rdy = 1'b1;
         end
      join
      chk("accept_after_handshake", 32'(b), 32'(hs_cyc + 1));
      drain();

      // Reset during RUN aborts the operation
      send(8'h5A, 4'd10, a);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_data", 32'(out_data), 32'd0);
      send(8'h03, 4'd3, a); drain();

      // Randomised traffic with random output backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(N'($urandom), C'($urandom_range(0, (1 << C) - 1)), a);
      end
      drain();
      rand_rdy = 1'b0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
